// File: rtl/inst_dispatch.sv
// inst_dispatch: pops 160-bit instructions, splits them into ILC/W2C bundles and retires on unit completion.
// Optional watchdog on the WAIT state is built when INST_DISPATCH_WDOG_EN is defined.
module inst_dispatch #(
   parameter int INST_LEN    = 160,
   parameter int CNT_W       = 16,
   parameter int WDOG_CYCLES = 65535
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   input  logic [INST_LEN-1:0] instruct,
   input  logic                inst_empty,
   output logic                inst_req,
   output logic [59:0]         ilc_cmd,
   output logic                ilc_start,
   input  logic                ilc_done,
   output logic [76:0]         w2c_cmd,
   output logic                w2c_start,
   input  logic                w2c_done,
   output logic [CNT_W-1:0]    inst_cnt,
   output logic                all_done,
   output logic                timeout
);
   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT} state_t;
   state_t state_q, state_d;
   logic [59:0] ilc_cmd_q;
   logic [76:0] w2c_cmd_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic ilc_pend_q, ilc_pend_d, w2c_pend_q, w2c_pend_d;
   logic timeout_q, timeout_d;
   logic ilc_rem, w2c_rem, wdog_hit;
   assign ilc_rem = ilc_pend_q & ~ilc_done;
   assign w2c_rem = w2c_pend_q & ~w2c_done;
`ifdef INST_DISPATCH_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wcnt_q, wcnt_d;
   assign wcnt_d   = (state_q == WAIT) ? wcnt_q + 1'b1 : '0;
   assign wdog_hit = (wcnt_q == WW'(WDOG_CYCLES - 1));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) wcnt_q <= '0;
      else        wcnt_q <= wcnt_d;
`else
   logic [31:0] unused_wdog;
   assign unused_wdog = WDOG_CYCLES;
   assign wdog_hit    = 1'b0;
`endif
   generate
      if (INST_LEN > 137) begin : g_spare
         logic unused_bits;
         assign unused_bits = ^instruct[INST_LEN-1:137];
      end
   endgenerate
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ilc_pend_d = ilc_pend_q;
      w2c_pend_d = w2c_pend_q;
      timeout_d  = timeout_q;
      case (state_q)
         IDLE:  state_d = (run && !inst_empty && !timeout_q) ? FETCH : IDLE;
         FETCH: state_d = ISSUE;
         ISSUE: begin
            ilc_pend_d = 1'b1;
            w2c_pend_d = w2c_cmd_q[0];
            state_d    = WAIT;
         end
         WAIT: begin
            ilc_pend_d = ilc_rem;
            w2c_pend_d = w2c_rem;
            if (!ilc_rem && !w2c_rem) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = (run && !inst_empty) ? FETCH : IDLE;
            end else if (wdog_hit) begin
               timeout_d  = 1'b1;
               ilc_pend_d = 1'b0;
               w2c_pend_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ilc_cmd_q  <= '0;
         w2c_cmd_q  <= '0;
         cnt_q      <= '0;
         ilc_pend_q <= 1'b0;
         w2c_pend_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ilc_pend_q <= ilc_pend_d;
         w2c_pend_q <= w2c_pend_d;
         timeout_q  <= timeout_d;
         // Capture on the pop edge, before the FIFO head advances
         if (state_q == FETCH) begin
            ilc_cmd_q <= instruct[59:0];
            w2c_cmd_q <= instruct[136:60];
         end
      end
   end
   assign inst_req  = (state_q == FETCH);
   assign ilc_start = (state_q == ISSUE);
   assign w2c_start = ilc_start & w2c_cmd_q[0];
   assign all_done  = (state_q == IDLE) & inst_empty;
   assign ilc_cmd   = ilc_cmd_q;
   assign w2c_cmd   = w2c_cmd_q;
   assign inst_cnt  = cnt_q;
   assign timeout   = timeout_q;
endmodule

// File: doc/inst_dispatch.md
Name: inst_dispatch

Overview:
- Sits directly downstream of the instruction FIFO.
- Pops one 160-bit instruction at a time and splits it into an ILC (input line controller / BSR) command bundle and a W2C (write-back / pooling / bias) command bundle.
- Issues each bundle with a one-cycle start pulse and holds off the next pop until every issued unit reports done.
- Provides instruction count and completion status to the top-level controller.

Parameters:
- INST_LEN, 160: instruction word width. Must be at least 137.
- CNT_W, 16: width of the retired-instruction counter.
- WDOG_CYCLES, 65535: WAIT-state timeout limit. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level enable; dispatch proceeds while high
- instruct  in  INST_LEN  head-of-FIFO instruction; valid whenever inst_empty=0
- inst_empty  in  1  FIFO empty
- inst_req  out  1  pop strobe; FIFO advances on the clock edge where it is high
- ilc_cmd  out  60  registered instruct[59:0]: st_addr[35:0], ispad[36], linelen[45:37], bsr_iszero[49:46], bsr_buffermux[57:50], fromfifo[58], tofifo[59]
- ilc_start  out  1  one-cycle issue pulse for ILC
- ilc_done  in  1  one-cycle ILC completion pulse
- w2c_cmd  out  77  registered instruct[136:60]; bit 0 = is_w2c_back, then w2c_st_addr ... bias_shift in instruction order
- w2c_start  out  1  one-cycle issue pulse for W2C
- w2c_done  in  1  one-cycle W2C completion pulse
- inst_cnt  out  CNT_W  instructions retired since reset
- all_done  out  1  state==IDLE and inst_empty=1 (combinational from state and input)
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - inst_req, ilc_start, w2c_start, timeout = 0.
  - ilc_cmd, w2c_cmd, inst_cnt = 0.
  - Pending flags ilc_pend and w2c_pend = 0.
  - Reset asserted mid-operation abandons the instruction in flight; no retire, no further pulses.
- States: IDLE, FETCH, ISSUE, WAIT.
- IDLE:
  - If run=1 and inst_empty=0, go to FETCH. Otherwise stay.
- FETCH (1 cycle):
  - inst_req=1.
  - At the same edge, ilc_cmd and w2c_cmd capture instruct. The word is sampled before the FIFO index advances.
  - Go to ISSUE.
- ISSUE (1 cycle):
  - ilc_start=1 and ilc_pend<=1.
  - If w2c_cmd[0]=1: w2c_start=1 and w2c_pend<=1. Otherwise w2c_start=0 and w2c_pend stays 0.
  - Go to WAIT.
  - ilc_done/w2c_done arriving in the ISSUE cycle are ignored; units must not respond in the same cycle as start.
- WAIT:
  - ilc_done clears ilc_pend; w2c_done clears w2c_pend.
  - "Clear" means the pending flag masked by the done input in the same cycle, so both dones in one cycle retire immediately.
  - A done pulse for a unit not pending is ignored.
  - When both flags are clear: inst_cnt<=inst_cnt+1, wrapping at 2^CNT_W. Then:
    - run=1 and inst_empty=0: go directly to FETCH (back-to-back; 3-cycle minimum per instruction).
    - Otherwise: go to IDLE.
- Dropping run mid-instruction does not abort; the current instruction completes, then the block parks in IDLE.
- inst_req is asserted only in FETCH. It is never asserted while inst_empty=1.
- Command outputs stay stable from ISSUE until the next FETCH edge.
- Without the optional feature, timeout is tied to 0.

Optional Feature:
INST_DISPATCH_WDOG_EN
- Defined:
  - A counter of WAIT cycles, clog2(WDOG_CYCLES+1) bits wide, is cleared on entry to WAIT.
  - When it reaches WDOG_CYCLES with any flag still pending, timeout<=1 (sticky until reset).
  - Both pending flags are cleared, the instruction is not counted, and the FSM goes to IDLE.
  - While timeout=1, IDLE does not fetch.
- Not defined:
  - No counter is built; timeout=0 constantly. WAIT waits indefinitely.

Test Plan:
- Reset then 3 instructions, all with bit60=0; ilc_done returned 2 cycles after each ilc_start -> 3 inst_req pulses, 0 w2c_start, inst_cnt=3, all_done=1.
- Instruction with bit60=1, ilc_done at +5 and w2c_done at +2 -> retire only after ilc_done, inst_cnt=1; ilc_cmd=instruct[59:0] and w2c_cmd=instruct[136:60] bit-exact.
- Both dones in the same WAIT cycle with FIFO non-empty and run=1 -> next inst_req asserted the following cycle (back-to-back, 3-cycle period when dones return at +1).
- run dropped during WAIT with 2 instructions queued -> current instruction retires, state IDLE, inst_req stays 0 and all_done=0; raising run resumes.
- rst_n pulsed low during WAIT -> outputs zero immediately (asynchronous); a subsequent late ilc_done is ignored; inst_cnt=0.
- With INST_DISPATCH_WDOG_EN and WDOG_CYCLES=8, ilc_done withheld -> timeout=1 after 8 WAIT cycles, state IDLE, no further inst_req, inst_cnt unchanged.
